// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {instr, pc}
// with combinational decode of the head entry and halt/flush control.
module fetch_decode_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic                     out_illegal,
  output logic                     out_halt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 64;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               halt_seen_q, halt_seen_d;

  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Handshake qualifiers; in_ready deliberately ignores out_ready
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    in_ready  = !full && !halt_seen_q && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;
  end

  // Next-state for pointers, occupancy, halt latch and storage; flush wins
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    halt_seen_d = halt_seen_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      halt_seen_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_instr, in_pc};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (in_instr == HALT_INSN) begin
          halt_seen_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Entry storage; contents are not reset, occupancy tracks validity
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Head entry and its decode fields
  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_instr   = head[63:32];
    out_pc      = head[31:0];
    out_opcode  = out_instr[6:0];
    out_rd      = out_instr[11:7];
    out_rs1     = out_instr[19:15];
    out_rs2     = out_instr[24:20];
    out_illegal = (out_instr[1:0] != 2'b11);
    out_halt    = (out_instr == HALT_INSN);
    count       = count_q;
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer (DEPTH=4).
module tb_fetch_decode_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_illegal;
  logic        out_halt;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_decode_buffer #(.DEPTH(4), .HALT_INSN(32'hFFFF_FFFF)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal), .out_halt(out_halt), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the fetch side, then let combinational outputs settle
  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Fill with out_ready low, then drain in order
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h0000_0013, 32'(4 * i));
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    offer(1'b1, 32'h0000_0013, 32'h10);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("full_no_push", 64'(count), 64'd4);
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      tick();
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid_end", 64'(out_valid), 64'd0);

    // Continuous push with concurrent pop: occupancy stays at one
    offer(1'b1, 32'h0000_0013, 32'h100);
    tick();
    for (int k = 1; k < 10; k++) begin
      offer(1'b1, 32'h0000_0013, 32'(32'h100 + 4 * k));
      chk("wrap_count", 64'(count), 64'd1);
      chk("wrap_pc", 64'(out_pc), 64'(32'h100 + 4 * (k - 1)));
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    chk("wrap_last_pc", 64'(out_pc), 64'h124);
    tick();
    chk("wrap_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Decode fields and head stability under backpressure
    offer(1'b1, 32'h00B5_0533, 32'h200);
    tick();
    offer(1'b1, 32'h0000_0000, 32'h204);
    chk("dec_opcode", 64'(out_opcode), 64'h33);
    chk("dec_rd", 64'(out_rd), 64'd10);
    chk("dec_rs1", 64'(out_rs1), 64'd10);
    chk("dec_rs2", 64'(out_rs2), 64'd11);
    chk("dec_legal", 64'(out_illegal), 64'd0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("dec_hold_instr", 64'(out_instr), 64'h00B5_0533);
    chk("dec_hold_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("dec_illegal", 64'(out_illegal), 64'd1);
    chk("dec_pc2", 64'(out_pc), 64'h204);
    tick();
    chk("dec_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Halt blocks further input
    offer(1'b1, 32'h0000_0013, 32'h300);
    tick();
    offer(1'b1, 32'hFFFF_FFFF, 32'h304);
    chk("halt_push_ready", 64'(in_ready), 64'd1);
    tick();
    offer(1'b1, 32'h0000_0033, 32'h308);
    chk("halt_block", 64'(in_ready), 64'd0);
    tick();
    chk("halt_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    #1;
    chk("halt_head0_pc", 64'(out_pc), 64'h300);
    chk("halt_head0_flag", 64'(out_halt), 64'd0);
    tick();
    chk("halt_head1_pc", 64'(out_pc), 64'h304);
    chk("halt_head1_flag", 64'(out_halt), 64'd1);
    tick();
    chk("halt_drained", 64'(out_valid), 64'd0);
    chk("halt_still_blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_clear_halt", 64'(in_ready), 64'd1);

    // Flush with three entries and a live offer
    offer(1'b1, 32'h0000_0013, 32'h400);
    tick();
    offer(1'b1, 32'h0000_0013, 32'h404);
    tick();
    offer(1'b1, 32'hFFFF_FFFF, 32'h408);
    tick();
    chk("pre_flush_count", 64'(count), 64'd3);
    chk("pre_flush_halt", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    offer(1'b1, 32'h0000_0013, 32'h500);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready_after", 64'(in_ready), 64'd1);
    offer(1'b1, 32'h0000_0013, 32'h600);
    tick();
    offer(1'b1, 32'h0000_0013, 32'h604);
    chk("post_flush_head", 64'(out_pc), 64'h600);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("pre_rst_count", 64'(count), 64'd2);

    // Asynchronous reset between edges
    #2 RST = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    RST = 1'b0;
    offer(1'b1, 32'h0000_0013, 32'h700);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("first_push_count", 64'(count), 64'd1);
    chk("first_push_pc", 64'(out_pc), 64'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout observed=stalled expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of buffered entries, a power of two and at least 2.
REQ-002 The module SHALL have parameter HALT_INSN, default 32'hFFFF_FFFF, meaning the encoding treated as halt.
REQ-003 The module SHALL have port CLK  input  1  meaning the single clock; every state element samples on its rising edge.
REQ-004 The module SHALL have port RST  input  1  meaning reset, asynchronous and active-high.
REQ-005 The module SHALL have port flush  input  1  meaning discard all entries (branch/exception redirect).
REQ-006 The module SHALL have port in_valid  input  1  meaning the fetch stage offers an instruction.
REQ-007 The module SHALL have port in_ready  output  1  meaning the buffer accepts the offer this cycle.
REQ-008 The module SHALL have port in_instr  input  32  meaning the raw instruction word.
REQ-009 The module SHALL have port in_pc  input  32  meaning the instruction address.
REQ-010 The module SHALL have port out_valid  output  1  meaning the head entry is valid.
REQ-011 The module SHALL have port out_ready  input  1  meaning the execute stage consumes the head.
REQ-012 The module SHALL have port out_instr  output  32  meaning the head instruction word.
REQ-013 The module SHALL have port out_pc  output  32  meaning the head address.
REQ-014 The module SHALL have port out_opcode  output  7  meaning out_instr[6:0].
REQ-015 The module SHALL have port out_rd, out_rs1, out_rs2  output  5 each  meaning bits [11:7], [19:15] and [24:20] of the head.
REQ-016 The module SHALL have port out_illegal  output  1  meaning head bits [1:0] != 2'b11.
REQ-017 The module SHALL have port out_halt  output  1  meaning the head equals HALT_INSN.
REQ-018 The module SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of occupied entries.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries holding {instr, pc}, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-020 in_ready SHALL be driven as !full && !halt_seen && !flush, and SHALL NOT depend combinationally on out_ready.
REQ-021 A push SHALL occur on in_valid && in_ready, writing at the write pointer; the entry SHALL be visible at the head no earlier than the next cycle, so latency is 1 cycle.
REQ-022 out_valid SHALL be driven as (count != 0).
REQ-023 A pop SHALL occur on out_valid && out_ready && !flush, advancing the read pointer.
REQ-024 All out_* data and decode fields SHALL be combinational from the head entry, and SHALL hold stable while out_valid && !out_ready.
REQ-025 When out_valid = 0, the out_* fields SHALL be don't-care, and the bench SHALL NOT check them.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 When full (count == DEPTH), in_ready SHALL be 0, even if a pop occurs in the same cycle.
REQ-028 When empty, no pop SHALL occur regardless of out_ready.
REQ-029 Pushing an instruction equal to HALT_INSN SHALL set halt_seen on the next edge; while halt_seen = 1, in_ready SHALL be 0, so no instruction past a halt enters the buffer.
REQ-030 halt_seen SHALL be cleared only by flush or by reset.
REQ-031 flush SHALL take priority over push and pop; on the next edge, pointers SHALL go to 0, count to 0 and halt_seen to 0.
REQ-032 The input offered during a flush cycle SHALL be dropped, and no pop SHALL be reported during it.
REQ-033 count SHALL never exceed DEPTH, and SHALL never underflow.

Reset
REQ-034 While RST = 1, pointers, count and halt_seen SHALL be 0, giving out_valid = 0 and in_ready = 1 (when flush = 0).
REQ-035 RST assertion mid-operation SHALL discard all entries immediately (asynchronously); storage contents need not be cleared.
REQ-036 The first push SHALL be possible on the first rising edge after RST deasserts.

Verification
REQ-037 Fill and drain: with DEPTH=4 and out_ready=0, push pc 0x0,0x4,0x8,0xC -> count=4, in_ready=0; then out_ready=1 -> pcs emerge in order over 4 cycles, count returns to 0.
REQ-038 Wrap-around: 10 continuous pushes with concurrent pops -> count steady at 1, every pc seen in order exactly once, pointers wrap at least twice.
REQ-039 Halt: push 0x00000013, then 0xFFFFFFFF, then 0x00000033 offered -> in_ready=0 after the halt push, the third instruction is not accepted, and out_halt=1 when the halt reaches the head.
REQ-040 Flush: count=3, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, the offered input is absent, and halt_seen is cleared.
REQ-041 Decode fields: push 0x00B50533 -> out_opcode=0x33, out_rd=10, out_rs1=10, out_rs2=11, out_illegal=0; push 0x00000000 -> out_illegal=1.
REQ-042 Async reset: assert RST between edges with count=2 -> out_valid falls immediately, and count=0 before the next edge.
